// File: rtl/key_irq_conditioner_if.sv
// Button-side signal bundle for key_irq_conditioner: raw pins in, debounced level and strobes out.
interface key_irq_conditioner_if #(
  parameter int N_CH = 3
);
  logic [N_CH-1:0] key_pin;
  logic [N_CH-1:0] key_level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;

  modport master (
    output key_pin,
    input  key_level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  key_pin,
    output key_level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/key_irq_conditioner.sv
// Push-button conditioner for the PIO interrupt input: per channel 2-FF sync,
// polarity normalization and a counter debounce FSM with press/release strobes.
module key_irq_conditioner #(
  parameter int N_CH       = 3,
  parameter int DB_CYCLES  = 500000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  key_irq_conditioner_if.slave   bus
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  // Sync flops reset to the idle pin level so reset itself never looks like a press.
  localparam logic [N_CH-1:0] PIN_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_e;

  logic [N_CH-1:0] s1_q, s1_d;
  logic [N_CH-1:0] s2_q, s2_d;
  logic [N_CH-1:0] r;

  always_comb begin
    s1_d = bus.key_pin;
    s2_d = s1_q;
    r    = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_q <= PIN_IDLE;
      s2_q <= PIN_IDLE;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      key_state_e       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             rel_q, rel_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
          RELEASED: begin
            if (r[gi]) begin
              state_d = PRESS_CHK;
              cnt_d   = '0;
            end
          end
          PRESS_CHK: begin
            if (!r[gi]) begin
              state_d = RELEASED;
            end else if (cnt_q == CNT_MAX) begin
              state_d = PRESSED;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (!r[gi]) begin
              state_d = RELEASE_CHK;
              cnt_d   = '0;
            end
          end
          RELEASE_CHK: begin
            if (r[gi]) begin
              state_d = PRESSED;
            end else if (cnt_q == CNT_MAX) begin
              state_d = RELEASED;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = RELEASED;
        endcase
      end

      always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
          state_q <= RELEASED;
          cnt_q   <= '0;
          level_q <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          press_q <= press_d;
          rel_q   <= rel_d;
        end
      end

      assign bus.key_level[gi]     = level_q;
      assign bus.press_pulse[gi]   = press_q;
      assign bus.release_pulse[gi] = rel_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_irq_conditioner.sv
// Bench for key_irq_conditioner: directed scenarios plus random pin activity,
// checked against a run-length model of the debounce rule.
module tb_key_irq_conditioner;

  localparam int N  = 3;
  localparam int DB = 8;
  localparam logic [N-1:0] IDLE = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  key_irq_conditioner_if #(.N_CH(N)) bus ();

  key_irq_conditioner #(
    .N_CH       (N),
    .DB_CYCLES  (DB),
    .ACTIVE_LOW (1)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Model: accepted level flips once the pin (seen two edges late) has
  // disagreed with it for DB+1 consecutive edges.
  logic [N-1:0] m_level, m_press, m_rel;
  int           run [N];
  logic [N-1:0] dq [$];
  wire  [3*N-1:0] obs = {bus.key_level, bus.press_pulse, bus.release_pulse};
  wire  [3*N-1:0] exp_v = {m_level, m_press, m_rel};

  task automatic model_edge();
    logic [N-1:0] tmp, rv;
    m_press = '0;
    m_rel   = '0;
    if (rst) begin
      m_level = '0;
      for (int c = 0; c < N; c++) run[c] = 0;
      dq.delete();
      dq.push_back(IDLE);
      dq.push_back(IDLE);
    end else begin
      tmp = dq.pop_front();
      rv  = ~tmp;
      dq.push_back(bus.key_pin);
      for (int c = 0; c < N; c++) begin
        if (rv[c] !== m_level[c]) begin
          run[c]++;
          if (run[c] == DB + 1) begin
            m_level[c] = rv[c];
            run[c]     = 0;
            if (rv[c]) m_press[c] = 1'b1;
            else       m_rel[c]   = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if ((m_press | m_rel) != '0)
      $display("t=%0t pin=%b level=%b press=%b release=%b", $time, bus.key_pin,
               bus.key_level, bus.press_pulse, bus.release_pulse);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_pin = 3'b111;
    for (int i = 0; i < 50; i++) begin
      tick();
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset_hold: got lvl/prs/rel=%b want all zero", obs);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (obs !== '0 || obs !== exp_v) begin
        bad++;
        $display("FAIL reset_idle: got %b want %b", obs, exp_v);
      end
    end
  endtask

  task automatic test_single_press();
    bus.key_pin = 3'b110;
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL single_press model cyc=%0d: got %b want %b", i, obs, exp_v);
      end
      if (i == 10) begin
        total++;
        if (bus.key_level !== 3'b001 || bus.press_pulse !== 3'b001) begin
          bad++;
          $display("FAIL single_press edge10: got lvl=%b prs=%b want lvl=001 prs=001",
                   bus.key_level, bus.press_pulse);
        end
      end
      if (i == 11) begin
        total++;
        if (bus.press_pulse !== 3'b000 || bus.key_level !== 3'b001) begin
          bad++;
          $display("FAIL single_press edge11: got lvl=%b prs=%b want lvl=001 prs=000",
                   bus.key_level, bus.press_pulse);
        end
      end
    end
  endtask

  task automatic test_bounce();
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < 10; i++) begin
        bus.key_pin = (i < 5) ? 3'b100 : 3'b110;
        tick();
        total++;
        if (obs !== exp_v || bus.key_level[1] !== 1'b0 || bus.press_pulse[1] !== 1'b0) begin
          bad++;
          $display("FAIL bounce rep=%0d cyc=%0d: got %b want %b", rep, i, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_release();
    bus.key_pin = 3'b111;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL release model cyc=%0d: got %b want %b", i, obs, exp_v);
      end
      if (i == 10) begin
        total++;
        if (bus.release_pulse !== 3'b001 || bus.key_level !== 3'b000) begin
          bad++;
          $display("FAIL release edge10: got lvl=%b rel=%b want lvl=000 rel=001",
                   bus.key_level, bus.release_pulse);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.key_pin = 3'b011;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset_mid hold cyc=%0d: got %b want all zero", i, obs);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset_mid model cyc=%0d: got %b want %b", i, obs, exp_v);
      end
      if (i < 10) begin
        total++;
        if (bus.press_pulse !== 3'b000) begin
          bad++;
          $display("FAIL reset_mid early cyc=%0d: got prs=%b want 000", i, bus.press_pulse);
        end
      end
      if (i == 10) begin
        total++;
        if (bus.press_pulse !== 3'b100 || bus.key_level !== 3'b100) begin
          bad++;
          $display("FAIL reset_mid edge10: got lvl=%b prs=%b want lvl=100 prs=100",
                   bus.key_level, bus.press_pulse);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    bus.key_pin = 3'b111;
    for (int i = 0; i < 15; i++) tick();
    bus.key_pin = 3'b000;
    for (int i = 0; i < 13; i++) begin
      tick();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL simultaneous model cyc=%0d: got %b want %b", i, obs, exp_v);
      end
      if (i == 10) begin
        total++;
        if (bus.press_pulse !== 3'b111 || bus.key_level !== 3'b111) begin
          bad++;
          $display("FAIL simultaneous edge10: got lvl=%b prs=%b want lvl=111 prs=111",
                   bus.key_level, bus.press_pulse);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pin;
    pin = bus.key_pin;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 99) < 8) pin[c] = ~pin[c];
      bus.key_pin = pin;
      rst = ($urandom_range(0, 399) == 0);
      tick();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL random cyc=%0d: got %b want %b", i, obs, exp_v);
      end
      total++;
      if ((bus.press_pulse & bus.release_pulse) !== '0) begin
        bad++;
        $display("FAIL random_exclusive cyc=%0d: got prs=%b rel=%b want disjoint",
                 i, bus.press_pulse, bus.release_pulse);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < N; c++) run[c] = 0;
    dq.push_back(IDLE);
    dq.push_back(IDLE);
    bus.key_pin = 3'b111;
    test_reset();
    test_single_press();
    test_bounce();
    test_release();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
